// File: rtl/median_filter.sv
// median_filter: three-stage pipelined median of three unsigned samples
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous reset, active-high
//   en_i     - triplet valid; d1_i/d2_i/d3_i are accepted on any edge where it is 1
//   d1_i..d3_i - unsigned samples
//   done_o   - one-cycle strobe per accepted triplet, two edges after acceptance
//   median_o - middle value of the triplet; holds the last result while done_o is 0
module median_filter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] d1_i,
    input  logic [DATA_WIDTH-1:0] d2_i,
    input  logic [DATA_WIDTH-1:0] d3_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] median_o
);
    logic [DATA_WIDTH-1:0] lo1_q, lo1_d, hi1_q, hi1_d, c1_q, c1_d;
    logic [DATA_WIDTH-1:0] a2_q, a2_d, lo2_q, lo2_d, med_q, med_d;
    logic                  v1_q, v2_q, done_q;
    // Data registers only load behind a valid flag; the max of stage 2 is never needed.
    always_comb begin
        lo1_d = en_i ? ((d1_i < d2_i) ? d1_i : d2_i) : lo1_q;
        hi1_d = en_i ? ((d1_i < d2_i) ? d2_i : d1_i) : hi1_q;
        c1_d  = en_i ? d3_i : c1_q;
        a2_d  = v1_q ? lo1_q : a2_q;
        lo2_d = v1_q ? ((hi1_q < c1_q) ? hi1_q : c1_q) : lo2_q;
        med_d = v2_q ? ((a2_q < lo2_q) ? lo2_q : a2_q) : med_q;
    end
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lo1_q  <= '0;
            hi1_q  <= '0;
            c1_q   <= '0;
            a2_q   <= '0;
            lo2_q  <= '0;
            med_q  <= '0;
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            lo1_q  <= lo1_d;
            hi1_q  <= hi1_d;
            c1_q   <= c1_d;
            a2_q   <= a2_d;
            lo2_q  <= lo2_d;
            med_q  <= med_d;
            v1_q   <= en_i;
            v2_q   <= v1_q;
            done_q <= v2_q;
        end
    end
    assign done_o   = done_q;
    assign median_o = med_q;
endmodule

// File: tb/tb_median_filter.sv
// tb_median_filter: directed stimulus with a sorted-triplet reference model and per-cycle compare
module tb_median_filter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en_i = 1'b0;
    logic [7:0] d1_i = '0, d2_i = '0, d3_i = '0;
    logic       done_o;
    logic [7:0] median_o;
    int         passed = 0, total = 0;
    int         e = 0;
    bit         exp_v [1024];
    int         exp_m [1024];
    int         last_med = 0;
    int         got_q [$];

    median_filter #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i),
        .d1_i(d1_i), .d2_i(d2_i), .d3_i(d3_i),
        .done_o(done_o), .median_o(median_o)
    );

    always #10 clk = ~clk;

    function automatic int med3(input int a, input int b, input int c);
        int q [$];
        q = '{a, b, c};
        q.sort();
        return q[1];
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    endtask

    // Model: a triplet accepted at edge e must appear right after edge e+2.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 1024; i++) exp_v[i] = 1'b0;
        end else if (en_i) begin
            exp_v[(e + 2) % 1024] = 1'b1;
            exp_m[(e + 2) % 1024] = med3(d1_i, d2_i, d3_i);
        end
        e++;
    end

    always @(negedge clk) begin
        if (e > 0) begin
            if (rst_n) begin
                last_med = 0;
                chk("reset_done", done_o, 0);
                chk("reset_median", median_o, 0);
            end else begin
                if (exp_v[(e - 1) % 1024]) last_med = exp_m[(e - 1) % 1024];
                chk("done", done_o, exp_v[(e - 1) % 1024]);
                chk("median", median_o, last_med);
                if (done_o) got_q.push_back(median_o);
            end
        end
    end

    task automatic step(input logic en, input int a, input int b, input int c);
        en_i = en;
        d1_i = a[7:0];
        d2_i = b[7:0];
        d3_i = c[7:0];
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'hAA, 8'h55, 8'h0F);
    endtask

    initial begin
        int want [$];
        want = '{2, 5, 5, 5, 5, 5, 5, 7, 128, 255, 2, 5, 128, 7, 20, 4, 2};
        chk("model_perm", med3(5, 9, 3), 5);
        chk("model_tie", med3(7, 1, 7), 7);
        chk("model_span", med3(255, 0, 128), 128);
        repeat (2) @(posedge clk);
        #2;
        chk("reset_median_lit", median_o, 0);
        rst_n = 1'b0;
        step(1'b1, 1, 2, 3);
        step(1'b0, 4, 5, 6);
        step(1'b0, 7, 8, 9);
        idle(20);
        chk("hold_median_lit", median_o, 2);
        step(1'b1, 9, 3, 5);
        step(1'b1, 9, 5, 3);
        step(1'b1, 3, 9, 5);
        step(1'b1, 3, 5, 9);
        step(1'b1, 5, 9, 3);
        step(1'b1, 5, 3, 9);
        idle(3);
        step(1'b1, 7, 7, 1);
        step(1'b0, 0, 0, 0);
        step(1'b1, 0, 255, 128);
        step(1'b0, 0, 0, 0);
        step(1'b1, 255, 255, 255);
        idle(3);
        step(1'b1, 1, 2, 3);
        step(1'b1, 9, 3, 5);
        step(1'b1, 0, 255, 128);
        step(1'b1, 7, 7, 1);
        idle(3);
        step(1'b1, 10, 20, 30);
        step(1'b0, 99, 99, 99);
        step(1'b1, 6, 2, 4);
        idle(3);
        step(1'b1, 1, 2, 3);
        step(1'b0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk("midreset_median_lit", median_o, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        idle(2);
        chk("post_reset_median_lit", median_o, 0);
        step(1'b1, 3, 1, 2);
        idle(3);
        chk("result_count", got_q.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            chk($sformatf("result_%0d", i), (i < got_q.size()) ? got_q[i] : -1, want[i]);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
